wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter placed in front of the peripheral bus.
- Master 0 is the host command master. Master 1 is an auxiliary requester (DMA/streaming engine).
- Grants the single slave-side bus to one master per cycle (CYC-to-CYC ownership) with round-robin fairness.
- A watchdog terminates hung slave transactions with an error pulse so the host path never deadlocks.

Parameters:
- TIMEOUT, 1024: cycles a granted STB may wait for ACK before the watchdog fires (legal range 2..65535).
- TO_CNT_W, 16: width of the saturating timeout event counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- m0_adr_i/m1_adr_i  in  32  master address.
- m0_dat_i/m1_dat_i  in  32  master write data.
- m0_dat_o/m1_dat_o  out  32  read data to master.
- m0_stb_i/m1_stb_i, m0_cyc_i/m1_cyc_i, m0_we_i/m1_we_i  in  1  master strobe, cycle, write enable.
- m0_sel_i/m1_sel_i  in  4  byte selects.
- m0_ack_o/m1_ack_o  out  1  acknowledge to master.
- m0_err_o/m1_err_o  out  1  one-cycle timeout error pulse.
- s_adr_o  out  32  slave address.
- s_dat_o  out  32  slave write data.
- s_dat_i  in  32  slave read data.
- s_stb_o, s_cyc_o, s_we_o  out  1  slave strobe, cycle, write enable.
- s_sel_o  out  4  slave byte selects.
- s_ack_i  in  1  slave acknowledge.
- grant  out  2  one-hot current owner (00 = none).
- timeout_count  out  TO_CNT_W  saturating count of watchdog events.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, grant=00, last_grant=1 (master 0 wins the first tie), watchdog=0, timeout_count=0.
  - All err outputs 0.
  - Slave-side controls are gated by grant, so s_stb_o, s_cyc_o and s_we_o read 0 immediately, even mid-transaction.
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: master 0 / master 1 owns the bus.
  - RECOVER: after a timeout, waiting for the offending master to drop CYC.
- Arbitration is registered:
  - A request is mX_cyc_i high, sampled in IDLE at edge N; grant is visible after edge N.
  - Only one master requesting: that master is granted.
  - Both requesting: grant the master not equal to last_grant; last_grant updates on every grant.
- Ownership:
  - The owner keeps the bus while its cyc is high; no preemption, including across multiple STB beats.
  - When the owner drops cyc and the other master's cyc is high at the same edge, grant transfers directly (OWN0 to OWN1 or OWN1 to OWN0), with no IDLE bubble.
  - Otherwise go to IDLE.
- Datapath (combinational):
  - s_adr/dat/we/sel take the owner's signals; s_stb_o = owner stb and not RECOVER; s_cyc_o likewise.
  - All slave outputs are zero when grant=00.
  - s_ack_i routes only to the owner's ack; the non-owner's ack is 0.
  - s_dat_i drives both m0_dat_o and m1_dat_o; only the ack qualifies it.
- Watchdog:
  - Counts while in OWNx with stb high and s_ack_i low; clears on ack, on stb low, and on any state change.
  - Fires when the count reaches TIMEOUT-1 with no ack:
    - mX_err_o pulses for exactly one cycle to the owner.
    - timeout_count increments, saturating at all-ones.
    - State goes to RECOVER, where slave stb/cyc are forced low.
  - RECOVER exits to IDLE once the owner drops cyc. Ownership is not transferred during RECOVER; last_grant still marks the offender.
- Simultaneous events:
  - Ack arriving in the same cycle the watchdog would fire: the ack wins, with no err and no count.
  - A late s_ack_i during RECOVER is ignored and not routed.
- Non-owner masters see ack=0 and err=0 and simply wait, with their cyc held.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to 0x00000010 and the slave acks after 3 cycles.
  - Required: grant=01 one cycle after cyc; s_adr_o=0x10 and s_dat_o=0xDEADBEEF; m0_ack_o pulses once; m1_ack_o stays 0; grant=00 after m0 drops cyc.
- Simultaneous request from reset: m0 and m1 raise cyc in the same cycle, each doing one read.
  - Required: m0 is granted first; the grant transfers to m1 on the edge m0 drops cyc, with no IDLE cycle.
  - A second simultaneous request then grants m1 first, because last_grant=0.
- Burst hold: m1 holds cyc over 4 stb/ack beats while m0 requests.
  - Required: m0 stays ungranted until m1 drops cyc; m0 sees no ack during m1's beats.
- Timeout: with TIMEOUT=8, m0 reads and the slave never acks.
  - Required: m0_err_o is high exactly one cycle, 7 cycles after stb is first seen granted; s_stb_o and s_cyc_o go to 0; timeout_count=1; RECOVER holds until m0 drops cyc, then IDLE.
  - Repeat so the count saturates at 0xFFFF with TO_CNT_W=16.
- Ack/timeout race: with TIMEOUT=8, the slave acks on the firing cycle.
  - Required: normal ack, no err, timeout_count unchanged.
- Reset mid-transaction: assert rst low asynchronously while m1 is granted and its stb is high.
  - Required: grant=00 and s_cyc_o=0 before the next clock edge; after release, m1 is regranted if its cyc is still high.

Source files
------------

// File: rtl/wb_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter_if
// Wishbone classic link between one initiator and one target.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface wb_bus_arbiter_if;
  logic [31:0] adr;
  logic [31:0] dat_w;   // initiator -> target data
  logic [31:0] dat_r;   // target -> initiator data
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic        ack;
  logic        err;

  // Initiator side of the link
  modport master (
    output adr, dat_w, stb, cyc, we, sel,
    input  dat_r, ack, err
  );

  // Target side of the link
  modport slave (
    input  adr, dat_w, stb, cyc, we, sel,
    output dat_r, ack, err
  );
endinterface

`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
// Two-master / one-slave Wishbone arbiter with round-robin CYC ownership and
// a watchdog that terminates hung slave transactions with an error pulse.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_bus_arbiter #(
  parameter int TIMEOUT  = 1024,
  parameter int TO_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,            // asynchronous, active low
  wb_bus_arbiter_if.slave     m0,
  wb_bus_arbiter_if.slave     m1,
  wb_bus_arbiter_if.master    s,
  output logic [1:0]          grant,
  output logic [TO_CNT_W-1:0] timeout_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN0    = 2'd1,
    OWN1    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // Watchdog compares against TIMEOUT-1; TIMEOUT is at most 65535
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic        last_grant;       // 0: master 0 was granted last, 1: master 1
  logic        last_grant_next;
  logic [15:0] wd;
  logic [15:0] wd_next;

  logic owner0;
  logic owner1;
  logic own_active;
  logic owner_cyc;
  logic owner_stb;
  logic fire;

  // Owner decode: in RECOVER the offender (last_grant) still owns the bus
  always_comb begin
    owner0     = (state == OWN0) || ((state == RECOVER) && !last_grant);
    owner1     = (state == OWN1) || ((state == RECOVER) &&  last_grant);
    own_active = (state == OWN0) || (state == OWN1);
    owner_cyc  = (owner0 && m0.cyc) || (owner1 && m1.cyc);
    owner_stb  = (owner0 && m0.stb) || (owner1 && m1.stb);
    // An ack in the firing cycle wins over the watchdog
    fire       = own_active && owner_cyc && owner_stb && !s.ack && (wd == WD_LIMIT);
  end

  assign grant = {owner1, owner0};

  // Slave-side mux: follows the owner, zero when nobody owns the bus
  always_comb begin
    s.adr   = 32'd0;
    s.dat_w = 32'd0;
    s.we    = 1'b0;
    s.sel   = 4'd0;
    if (owner0) begin
      s.adr   = m0.adr;
      s.dat_w = m0.dat_w;
      s.we    = m0.we;
      s.sel   = m0.sel;
    end else if (owner1) begin
      s.adr   = m1.adr;
      s.dat_w = m1.dat_w;
      s.we    = m1.we;
      s.sel   = m1.sel;
    end
    // Strobe and cycle are withheld while recovering from a timeout
    s.stb = owner_stb && own_active;
    s.cyc = owner_cyc && own_active;
  end

  // Master-side returns: read data is broadcast, ack/err qualify it per owner
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = s.ack && own_active && owner0;
  assign m1.ack   = s.ack && own_active && owner1;
  assign m0.err   = fire && owner0;
  assign m1.err   = fire && owner1;

  // Next-state, round-robin arbitration and watchdog next value
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    wd_next         = 16'd0;
    case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          if (last_grant) begin
            state_next      = OWN0;
            last_grant_next = 1'b0;
          end else begin
            state_next      = OWN1;
            last_grant_next = 1'b1;
          end
        end else if (m0.cyc) begin
          state_next      = OWN0;
          last_grant_next = 1'b0;
        end else if (m1.cyc) begin
          state_next      = OWN1;
          last_grant_next = 1'b1;
        end
      end
      OWN0: begin
        if (!m0.cyc) begin
          if (m1.cyc) begin
            state_next      = OWN1;
            last_grant_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (fire) begin
          state_next = RECOVER;
        end
      end
      OWN1: begin
        if (!m1.cyc) begin
          if (m0.cyc) begin
            state_next      = OWN0;
            last_grant_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end else if (fire) begin
          state_next = RECOVER;
        end
      end
      RECOVER: begin
        if (!owner_cyc) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Watchdog counts only while a stable owner waits on an ack
    if ((state_next == state) && own_active && owner_stb && !s.ack)
      wd_next = wd + 16'd1;
  end

  // State, arbitration history and watchdog registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wd         <= 16'd0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      wd         <= wd_next;
    end
  end

  // Saturating count of watchdog events
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_count <= '0;
    end else if (fire && (timeout_count != {TO_CNT_W{1'b1}})) begin
      timeout_count <= timeout_count + TO_CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_bus_arbiter
// Self-checking bench: directed scenarios plus a randomized run compared
// against a transaction-level ownership model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_bus_arbiter;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       grant;
  logic [CNT_W-1:0] tocnt;
  int               errors = 0;
  int               checks = 0;

  wb_bus_arbiter_if m0_if ();
  wb_bus_arbiter_if m1_if ();
  wb_bus_arbiter_if s_if ();

  wb_bus_arbiter #(.TIMEOUT(TIMEOUT), .TO_CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
    .grant(grant), .timeout_count(tocnt)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, whether it is recovering, wait length
  int model_owner;
  bit model_rec;
  int model_last;
  int model_wait;
  int model_tos;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.adr = 0; m0_if.dat_w = 0; m0_if.sel = 0;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.adr = 0; m1_if.dat_w = 0; m1_if.sel = 0;
    s_if.ack = 0; s_if.dat_r = 32'h0; s_if.err = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  function automatic bit model_fire();
    bit c, st;
    if (model_owner < 0 || model_rec) return 0;
    c  = (model_owner == 0) ? m0_if.cyc : m1_if.cyc;
    st = (model_owner == 0) ? m0_if.stb : m1_if.stb;
    return c && st && !s_if.ack && (model_wait == TIMEOUT - 1);
  endfunction

  // Advance the model across one clock edge using the current inputs
  task automatic model_step();
    bit c[2];
    bit st[2];
    c[0] = m0_if.cyc; c[1] = m1_if.cyc;
    st[0] = m0_if.stb; st[1] = m1_if.stb;
    if (model_owner < 0) begin
      if (c[0] && c[1]) model_owner = 1 - model_last;
      else if (c[0]) model_owner = 0;
      else if (c[1]) model_owner = 1;
      if (model_owner >= 0) model_last = model_owner;
      model_wait = 0;
    end else if (model_rec) begin
      if (!c[model_owner]) begin
        model_owner = -1;
        model_rec = 0;
      end
    end else if (!c[model_owner]) begin
      if (c[1 - model_owner]) begin
        model_owner = 1 - model_owner;
        model_last = model_owner;
      end else begin
        model_owner = -1;
      end
      model_wait = 0;
    end else if (model_fire()) begin
      model_rec = 1;
      model_wait = 0;
      if (model_tos < CNT_MAX) model_tos++;
    end else if (st[model_owner] && !s_if.ack) begin
      model_wait++;
    end else begin
      model_wait = 0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 rst = 1'b0;
    repeat (2) tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (s_if.cyc !== 1'b0 || s_if.stb !== 1'b0) begin errors++; $display("FAIL reset_slave got cyc=%b stb=%b exp 0 0", s_if.cyc, s_if.stb); end
    checks++; if (tocnt !== 4'd0) begin errors++; $display("FAIL reset_tocnt got=%0d exp=0", tocnt); end
    checks++; if (m0_if.err !== 1'b0 || m1_if.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b%b exp=00", m1_if.err, m0_if.err); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int acks0 = 0, acks1 = 0;
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = 1; m0_if.adr = 32'h10; m0_if.dat_w = 32'hDEADBEEF; m0_if.sel = 4'hF;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_pre_grant got=%b exp=00", grant); end
    tick(); #2;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", grant); end
    checks++; if (s_if.adr !== 32'h10 || s_if.dat_w !== 32'hDEADBEEF) begin errors++; $display("FAIL single_path got adr=%h dat=%h exp 10 deadbeef", s_if.adr, s_if.dat_w); end
    checks++; if (s_if.we !== 1'b1 || s_if.sel !== 4'hF || s_if.stb !== 1'b1) begin errors++; $display("FAIL single_ctl got we=%b sel=%h stb=%b exp 1 f 1", s_if.we, s_if.sel, s_if.stb); end
    for (int k = 0; k < 5; k++) begin
      s_if.ack = (k == 2);
      #1;
      if (m0_if.ack) acks0++;
      if (m1_if.ack) acks1++;
      tick();
      if (k == 2) m0_if.stb = 0;
    end
    s_if.ack = 0;
    checks++; if (acks0 !== 1) begin errors++; $display("FAIL single_m0_acks got=%0d exp=1", acks0); end
    checks++; if (acks1 !== 0) begin errors++; $display("FAIL single_m1_acks got=%0d exp=0", acks1); end
    m0_if.cyc = 0; #2;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_hold got=%b exp=01", grant); end
    tick(); #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_release got=%b exp=00", grant); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h100;
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h200;
    tick(); #2;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL simul_first got=%b exp=01", grant); end
    s_if.ack = 1; s_if.dat_r = 32'hA5A5_0001; #1;
    checks++; if (m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0 || m0_if.dat_r !== 32'hA5A5_0001) begin errors++; $display("FAIL simul_ack0 got ack0=%b ack1=%b dat=%h exp 1 0 a5a50001", m0_if.ack, m1_if.ack, m0_if.dat_r); end
    tick();
    s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
    tick(); #2;
    checks++; if (grant !== 2'b10 || s_if.adr !== 32'h200) begin errors++; $display("FAIL simul_transfer got grant=%b adr=%h exp 10 200", grant, s_if.adr); end
    s_if.ack = 1; #1;
    checks++; if (m1_if.ack !== 1'b1 || m0_if.ack !== 1'b0) begin errors++; $display("FAIL simul_ack1 got ack1=%b ack0=%b exp 1 0", m1_if.ack, m0_if.ack); end
    tick();
    s_if.ack = 0; m1_if.cyc = 0; m1_if.stb = 0;
    tick(); #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL simul_idle got=%b exp=00", grant); end
    // Lone m0 transaction leaves master 0 as the last grantee
    m0_if.cyc = 1; m0_if.stb = 1;
    tick(); s_if.ack = 1;
    tick(); s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
    tick();
    m0_if.cyc = 1; m0_if.stb = 1; m1_if.cyc = 1; m1_if.stb = 1;
    tick(); #2;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL simul_rr got=%b exp=10", grant); end
    s_if.ack = 1;
    tick(); s_if.ack = 0; m1_if.cyc = 0; m1_if.stb = 0;
    tick(); #2;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL simul_back got=%b exp=01", grant); end
    m0_if.cyc = 0; m0_if.stb = 0;
    tick();
  endtask

  task automatic test_burst();
    int acks1 = 0, acks0 = 0, badgrant = 0;
    m1_if.cyc = 1;
    tick(); #2;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_grant got=%b exp=10", grant); end
    m0_if.cyc = 1; m0_if.stb = 1;
    for (int b = 0; b < 4; b++) begin
      m1_if.stb = 1; s_if.ack = 1; #1;
      if (m1_if.ack) acks1++;
      if (m0_if.ack) acks0++;
      if (grant !== 2'b10) badgrant++;
      tick();
      m1_if.stb = 0; s_if.ack = 0;
      tick();
    end
    checks++; if (acks1 !== 4) begin errors++; $display("FAIL burst_m1_acks got=%0d exp=4", acks1); end
    checks++; if (acks0 !== 0) begin errors++; $display("FAIL burst_m0_acks got=%0d exp=0", acks0); end
    checks++; if (badgrant !== 0) begin errors++; $display("FAIL burst_preempt got=%0d exp=0", badgrant); end
    m1_if.cyc = 0; #2;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_hold got=%b exp=10", grant); end
    tick(); #2;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL burst_handover got=%b exp=01", grant); end
    m0_if.cyc = 0; m0_if.stb = 0;
    tick();
  endtask

  task automatic test_timeout();
    int err_cnt = 0, err_at = -1, low_at = -1, err1 = 0;
    apply_reset();
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h40;
    tick(); #2;
    for (int k = 0; k < 10; k++) begin
      if (m0_if.err) begin err_cnt++; if (err_at < 0) err_at = k; end
      if (m1_if.err) err1++;
      if (!s_if.stb && !s_if.cyc && low_at < 0) low_at = k;
      tick(); #2;
    end
    checks++; if (err_cnt !== 1 || err_at !== 7) begin errors++; $display("FAIL to_err got cnt=%0d at=%0d exp 1 at 7", err_cnt, err_at); end
    checks++; if (err1 !== 0) begin errors++; $display("FAIL to_m1_err got=%0d exp=0", err1); end
    checks++; if (low_at !== 8) begin errors++; $display("FAIL to_gate got=%0d exp=8", low_at); end
    checks++; if (tocnt !== 4'd1) begin errors++; $display("FAIL to_count got=%0d exp=1", tocnt); end
    s_if.ack = 1; #1;
    checks++; if (m0_if.ack !== 1'b0) begin errors++; $display("FAIL to_late_ack got=%b exp=0", m0_if.ack); end
    tick(); s_if.ack = 0; #2;
    checks++; if (grant !== 2'b01 || s_if.cyc !== 1'b0) begin errors++; $display("FAIL to_recover got grant=%b cyc=%b exp 01 0", grant, s_if.cyc); end
    m0_if.cyc = 0; m0_if.stb = 0;
    tick(); #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_exit got=%b exp=00", grant); end
  endtask

  task automatic test_saturation();
    for (int n = 2; n <= 18; n++) begin
      m0_if.cyc = 1; m0_if.stb = 1;
      repeat (TIMEOUT + 1) tick();
      m0_if.cyc = 0; m0_if.stb = 0;
      tick(); #2;
      checks++; if (tocnt !== CNT_W'((n > CNT_MAX) ? CNT_MAX : n)) begin errors++; $display("FAIL sat_count got=%0d exp=%0d", tocnt, (n > CNT_MAX) ? CNT_MAX : n); end
    end
  endtask

  task automatic test_race();
    apply_reset();
    m0_if.cyc = 1; m0_if.stb = 1;
    tick();
    repeat (TIMEOUT - 1) tick();
    s_if.ack = 1; #1;
    checks++; if (m0_if.ack !== 1'b1 || m0_if.err !== 1'b0) begin errors++; $display("FAIL race_ack got ack=%b err=%b exp 1 0", m0_if.ack, m0_if.err); end
    tick(); s_if.ack = 0; #2;
    checks++; if (tocnt !== 4'd0 || s_if.stb !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL race_after got cnt=%0d stb=%b grant=%b exp 0 1 01", tocnt, s_if.stb, grant); end
    m0_if.cyc = 0; m0_if.stb = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    m1_if.cyc = 1; m1_if.stb = 1;
    tick(); #2;
    checks++; if (grant !== 2'b10 || s_if.cyc !== 1'b1) begin errors++; $display("FAIL rmid_pre got grant=%b cyc=%b exp 10 1", grant, s_if.cyc); end
    rst = 1'b0; #1;
    checks++; if (grant !== 2'b00 || s_if.cyc !== 1'b0 || s_if.stb !== 1'b0) begin errors++; $display("FAIL rmid_async got grant=%b cyc=%b stb=%b exp 00 0 0", grant, s_if.cyc, s_if.stb); end
    tick(); #2;
    rst = 1'b1;
    tick(); #2;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rmid_regrant got=%b exp=10", grant); end
    m1_if.cyc = 0; m1_if.stb = 0;
    tick();
  endtask

  task automatic test_random();
    logic [1:0]  eg;
    logic [31:0] eadr;
    bit          act, oc, os;
    apply_reset();
    model_owner = -1; model_rec = 0; model_last = 1; model_wait = 0; model_tos = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (m0_if.cyc) m0_if.cyc = ($urandom_range(0, 9) != 0); else m0_if.cyc = ($urandom_range(0, 2) == 0);
      if (m1_if.cyc) m1_if.cyc = ($urandom_range(0, 9) != 0); else m1_if.cyc = ($urandom_range(0, 2) == 0);
      m0_if.stb = m0_if.cyc && ($urandom_range(0, 7) != 0);
      m1_if.stb = m1_if.cyc && ($urandom_range(0, 7) != 0);
      m0_if.adr = $urandom; m1_if.adr = $urandom;
      s_if.ack = ($urandom_range(0, 9) == 0);
      #2;
      eg   = (model_owner < 0) ? 2'b00 : ((model_owner == 0) ? 2'b01 : 2'b10);
      eadr = (model_owner == 0) ? m0_if.adr : ((model_owner == 1) ? m1_if.adr : 32'h0);
      act  = (model_owner >= 0) && !model_rec;
      oc   = (model_owner == 0) ? m0_if.cyc : ((model_owner == 1) ? m1_if.cyc : 1'b0);
      os   = (model_owner == 0) ? m0_if.stb : ((model_owner == 1) ? m1_if.stb : 1'b0);
      checks++; if (grant !== eg) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, grant, eg); end
      checks++; if (s_if.adr !== eadr) begin errors++; $display("FAIL rnd_adr cyc=%0d got=%h exp=%h", cyc, s_if.adr, eadr); end
      checks++; if (s_if.cyc !== (act && oc) || s_if.stb !== (act && os)) begin errors++; $display("FAIL rnd_ctl cyc=%0d got cyc=%b stb=%b exp %b %b", cyc, s_if.cyc, s_if.stb, act && oc, act && os); end
      checks++; if (m0_if.ack !== (act && model_owner == 0 && s_if.ack) || m1_if.ack !== (act && model_owner == 1 && s_if.ack)) begin errors++; $display("FAIL rnd_ack cyc=%0d got %b%b", cyc, m1_if.ack, m0_if.ack); end
      checks++; if (m0_if.err !== (model_fire() && model_owner == 0) || m1_if.err !== (model_fire() && model_owner == 1)) begin errors++; $display("FAIL rnd_err cyc=%0d got %b%b exp fire=%b owner=%0d", cyc, m1_if.err, m0_if.err, model_fire(), model_owner); end
      checks++; if (tocnt !== CNT_W'(model_tos)) begin errors++; $display("FAIL rnd_tocnt cyc=%0d got=%0d exp=%0d", cyc, tocnt, model_tos); end
      model_step();
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_burst();
    test_timeout();
    test_saturation();
    test_race();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
